// File: rtl/pcie_phy_pkg.sv
// Shared PHY constants: symbol width, default COM filler and TX FSM state encoding.
package pcie_phy_pkg;

  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] COM_SYMBOL_DEFAULT = 8'hBC;

  localparam logic ST_SYNC   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  typedef enum logic {
    S_SYNC   = ST_SYNC,
    S_ACTIVE = ST_ACTIVE
  } state_t;

endpackage

// File: rtl/ser_8b_tx_piso_shift8.sv
// 8-bit load/shift PISO; the first-sent bit goes straight to dout on load.
module piso_shift8
  import pcie_phy_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             load,
  input  logic [SYM_W-1:0] din,
  output logic             dout
);

  logic [SYM_W-2:0] r_sreg;

  generate
    if (MSB_FIRST) begin : g_msb
      always_ff @(posedge clk_32f) begin
        if (reset) begin
          dout   <= 1'b0;
          r_sreg <= '0;
        end else if (load) begin
          dout   <= din[SYM_W-1];
          r_sreg <= din[SYM_W-2:0];
        end else begin
          dout   <= r_sreg[SYM_W-2];
          r_sreg <= {r_sreg[SYM_W-3:0], 1'b0};
        end
      end
    end else begin : g_lsb
      always_ff @(posedge clk_32f) begin
        if (reset) begin
          dout   <= 1'b0;
          r_sreg <= '0;
        end else if (load) begin
          dout   <= din[0];
          r_sreg <= din[SYM_W-1:1];
        end else begin
          dout   <= r_sreg[0];
          r_sreg <= {1'b0, r_sreg[SYM_W-2:1]};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ser_8b_tx.sv
// TX parallel-to-serial stage: COM preamble after reset, then data bytes or COM filler,
// one symbol per 8 clk_32f cycles.
module ser_8b_tx
  import pcie_phy_pkg::*;
#(
  parameter logic [SYM_W-1:0] COM_SYMBOL   = COM_SYMBOL_DEFAULT,
  parameter int               SYNC_SYMBOLS = 4,
  parameter bit               MSB_FIRST    = 1'b1
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [SYM_W-1:0] data_32_8,
  input  logic             valid_32_8,
  output logic             data_serial,
  output logic             valid_serial,
  output logic             sym_start,
  output logic             sync_done
);

  // sync_cnt only has to reach SYNC_SYMBOLS-1; the last preamble load moves to ACTIVE.
  localparam int SC_W = (SYNC_SYMBOLS > 1) ? $clog2(SYNC_SYMBOLS) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYNC_SYMBOLS - 1);

  logic [2:0]       r_bit_cnt;
  logic [SC_W-1:0]  r_sync_cnt;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_sync_last;
  logic [SYM_W-1:0] w_sym;
  logic             w_sym_valid;

  assign w_load      = (r_bit_cnt == 3'd0);
  assign w_sync_last = (r_sync_cnt == SC_LAST);

  always_ff @(posedge clk_32f) begin
    if (reset) r_bit_cnt <= 3'd0;
    else       r_bit_cnt <= r_bit_cnt + 3'd1;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) r_state <= S_SYNC;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sym       = COM_SYMBOL;
    w_sym_valid = 1'b0;
    case (r_state)
      S_SYNC: begin
        if (w_load && w_sync_last) w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (valid_32_8) begin
          w_sym       = data_32_8;
          w_sym_valid = 1'b1;
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_sync_cnt <= '0;
    end else if (w_load && (r_state == S_SYNC) && !w_sync_last) begin
      r_sync_cnt <= r_sync_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      valid_serial <= 1'b0;
      sym_start    <= 1'b0;
      sync_done    <= 1'b0;
    end else begin
      sym_start <= w_load;
      if (w_load) begin
        valid_serial <= w_sym_valid;
        if (r_state == S_ACTIVE) sync_done <= 1'b1;
      end
    end
  end

  piso_shift8 #(
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk_32f (clk_32f),
    .reset   (reset),
    .load    (w_load),
    .din     (w_sym),
    .dout    (data_serial)
  );

endmodule
